// File: rtl/alu_requester_if.sv
// Request/response channels between the issue logic and alu_requester.
// A beat transfers on a rising edge where valid && ready; the sender holds valid and payload stable until then.
interface alu_requester_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_ovf, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/alu_requester.sv
// Drives one request at a time onto the combinational ALU, waits SETTLE_CYCLES edges,
// then captures result/flags with SLT, overflow and flag-masking fix-ups applied.
module alu_requester #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_requester_if.slave       bus,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_op,
    input  logic [31:0]          alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_zero,
    input  logic                 alu_set,
    input  logic                 alu_overflow,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_BEQ = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] rsp_result_q;
    logic        rsp_cout_q;
    logic        rsp_zero_q;
    logic        rsp_ovf_q;
    logic        rsp_err_q;

    logic        ovf_add;
    logic        ovf_sub;
    logic [31:0] cap_result;
    logic        cap_cout;
    logic        cap_zero;
    logic        cap_ovf;
    logic        req_legal;

    // The ALU's own overflow flag is not trusted; overflow is rebuilt from sign bits.
    logic unused_alu_overflow;
    assign unused_alu_overflow = alu_overflow;

    assign req_legal = !(bus.req_op == 3'b011 || bus.req_op == 3'b101);

    always_comb begin
        ovf_add    = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
        ovf_sub    = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
        cap_result = alu_result;
        cap_cout   = 1'b0;
        cap_zero   = 1'b0;
        cap_ovf    = 1'b0;
        case (alu_op)
            OP_ADD: begin
                cap_cout = alu_cout;
                cap_zero = alu_zero;
                cap_ovf  = ovf_add;
            end
            OP_SUB: begin
                cap_cout = alu_cout;
                cap_zero = alu_zero;
                cap_ovf  = ovf_sub;
            end
            OP_BEQ: begin
                cap_result = 32'd0;
                cap_cout   = alu_cout;
                cap_zero   = alu_zero;
                cap_ovf    = ovf_sub;
            end
            OP_SLT: begin
                // The raw set bit is the sign of a-b; overflow flips its meaning.
                cap_result = {31'd0, alu_set ^ ovf_sub};
                cap_cout   = alu_cout;
                cap_zero   = alu_zero;
                cap_ovf    = ovf_sub;
            end
            OP_AND, OP_OR: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            alu_a        <= 32'd0;
            alu_b        <= 32'd0;
            alu_op       <= 3'd0;
            rsp_result_q <= 32'd0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (req_legal) begin
                            alu_a  <= bus.req_a;
                            alu_b  <= bus.req_b;
                            alu_op <= bus.req_op;
                            cnt    <= 8'(SETTLE_CYCLES);
                            state  <= ST_WAIT;
                        end else begin
                            rsp_result_q <= 32'd0;
                            rsp_cout_q   <= 1'b0;
                            rsp_zero_q   <= 1'b0;
                            rsp_ovf_q    <= 1'b0;
                            rsp_err_q    <= 1'b1;
                            state        <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        rsp_result_q <= cap_result;
                        rsp_cout_q   <= cap_cout;
                        rsp_zero_q   <= cap_zero;
                        rsp_ovf_q    <= cap_ovf;
                        rsp_err_q    <= 1'b0;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_err    = rsp_err_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_alu_requester.sv
// Bench for alu_requester: table vectors, randomized ops against an arithmetic reference,
// backpressure, illegal-op and mid-operation reset sequences.
module tb_alu_requester;
    localparam int S = 4;

    typedef struct packed {
        logic [31:0] result;
        logic        cout;
        logic        zero;
        logic        ovf;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_cout;
        logic        exp_zero;
        logic        exp_ovf;
        logic        exp_err;
        int          stall;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_zero;
    logic        alu_set;
    logic        alu_overflow;
    logic [1:0]  dbg_state;
    logic [32:0] alu_sum;

    alu_requester_if bus();

    int errors = 0;
    int checks = 0;
    logic [35:0] exp_q[$];
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [2:0]  last_op;

    alu_requester #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_zero     (alu_zero),
        .alu_set      (alu_set),
        .alu_overflow (alu_overflow),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Combinational ALU stand-in; cout is forced high on logic ops and overflow always high
    // so that missing flag masking shows up.
    always_comb begin
        case (alu_op)
            3'b000:  alu_sum = {1'b1, alu_a & alu_b};
            3'b001:  alu_sum = {1'b1, alu_a | alu_b};
            3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            default: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        endcase
        alu_result   = alu_sum[31:0];
        alu_cout     = alu_sum[32];
        alu_zero     = (alu_sum[31:0] == 32'd0);
        alu_set      = alu_sum[31];
        alu_overflow = 1'b1;
    end

    // reference model: exact signed arithmetic and unsigned compares
    function automatic rsp_t model_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t   r;
        longint exact;
        r = '0;
        case (op)
            3'b000: r.result = a & b;
            3'b001: r.result = a | b;
            3'b010: begin
                r.result = a + b;
                r.cout   = ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
                r.zero   = (r.result == 32'd0);
                exact    = longint'($signed(a)) + longint'($signed(b));
                r.ovf    = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            3'b110, 3'b100, 3'b111: begin
                exact  = longint'($signed(a)) - longint'($signed(b));
                r.cout = (a >= b);
                r.zero = (a == b);
                r.ovf  = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
                if (op == 3'b110) r.result = a - b;
                if (op == 3'b111) r.result = {31'd0, ($signed(a) < $signed(b))};
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check1({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check32({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
        check1({tag, "_rsp_cout"}, bus.rsp_cout, 1'b0);
        check1({tag, "_rsp_zero"}, bus.rsp_zero, 1'b0);
        check1({tag, "_rsp_ovf"}, bus.rsp_ovf, 1'b0);
        check1({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        check32({tag, "_alu_a"}, alu_a, 32'd0);
        check32({tag, "_alu_b"}, alu_b, 32'd0);
        check32({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
        check32({tag, "_dbg_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // driver: one full transaction; stall < 0 means rsp_ready is high before the response
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        rsp_t exp;
        int   lat;
        int   hold;
        bit   legal;
        legal = !(op == 3'b011 || op == 3'b101);
        exp   = rsp_t'(exp_q.pop_front());
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.rsp_ready = (stall < 0);
        check1("req_ready_idle", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        // request lines carry junk while busy; the block must ignore them
        bus.req_a  = $urandom;
        bus.req_b  = $urandom;
        bus.req_op = 3'($urandom_range(0, 7));
        lat = 0;
        while (!bus.rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.req_valid = 1'b0;
        check32("latency", 32'(lat), legal ? 32'(S) : 32'd0);
        if (legal) begin
            last_a  = a;
            last_b  = b;
            last_op = op;
        end
        hold = (stall < 0) ? 0 : stall;
        for (int c = 0; c <= hold; c++) begin
            check32("rsp_result", bus.rsp_result, exp.result);
            check1("rsp_cout", bus.rsp_cout, exp.cout);
            check1("rsp_zero", bus.rsp_zero, exp.zero);
            check1("rsp_ovf", bus.rsp_ovf, exp.ovf);
            check1("rsp_err", bus.rsp_err, exp.err);
            check1("rsp_valid_hold", bus.rsp_valid, 1'b1);
            check1("req_ready_busy", bus.req_ready, 1'b0);
            check32("alu_a_hold", alu_a, last_a);
            check32("alu_b_hold", alu_b, last_b);
            check32("alu_op_hold", {29'd0, alu_op}, {29'd0, last_op});
            if (c == hold) bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b0;
        check1("rsp_valid_drop", bus.rsp_valid, 1'b0);
        check1("req_ready_back", bus.req_ready, 1'b1);
    endtask

    vec_t        vt[13];
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          r_stall;
    logic        seen;

    initial begin
        vt[0]  = '{3'b000, 32'd512312,     32'd312312,     32'd311608,     1'b0, 1'b0, 1'b0, 1'b0, 3};
        vt[1]  = '{3'b010, 32'h7FFF_FFFF,  32'd318902,     32'h8004_DDB5,  1'b0, 1'b0, 1'b1, 1'b0, 0};
        vt[2]  = '{3'b110, 32'd7891932,    32'd318902,     32'd7573030,    1'b1, 1'b0, 1'b0, 1'b0, -1};
        vt[3]  = '{3'b100, 32'd65512,      32'd65512,      32'd0,          1'b1, 1'b1, 1'b0, 1'b0, 1};
        vt[4]  = '{3'b100, 32'd65512,      32'd65513,      32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[5]  = '{3'b111, 32'hFFFE_1EB3,  32'd412412,     32'd1,          1'b1, 1'b0, 1'b0, 1'b0, 0};
        vt[6]  = '{3'b111, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 2};
        vt[7]  = '{3'b001, 32'hF0F0_0000,  32'h0000_000F,  32'hF0F0_000F,  1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[8]  = '{3'b000, 32'h0000_000F,  32'h0000_00F0,  32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[9]  = '{3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1'b0, 1'b0, -1};
        vt[10] = '{3'b110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 1'b0, 1'b1, 1'b0, 0};
        vt[11] = '{3'b011, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 3};
        vt[12] = '{3'b101, 32'hDEAD_BEEF,  32'h0000_0001,  32'd0,          1'b0, 1'b0, 1'b0, 1'b1, -1};

        last_a        = 32'd0;
        last_b        = 32'd0;
        last_op       = 3'd0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_op    = 3'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            exp_q.push_back({vt[i].exp_result, vt[i].exp_cout, vt[i].exp_zero, vt[i].exp_ovf, vt[i].exp_err});
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].stall);
        end

        for (int i = 0; i < 40; i++) begin
            r_op    = 3'($urandom_range(0, 7));
            r_a     = $urandom;
            r_b     = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            r_stall = int'($urandom_range(0, 3)) - 1;
            exp_q.push_back(model_rsp(r_op, r_a, r_b));
            run_op(r_op, r_a, r_b, r_stall);
        end

        // reset in the middle of the settle window drops the request
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd200;
        bus.req_op    = 3'b010;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midwait");
        last_a  = 32'd0;
        last_b  = 32'd0;
        last_op = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (S + 3) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        bus.rsp_ready = 1'b0;
        check1("no_rsp_after_reset", seen, 1'b0);

        exp_q.push_back(model_rsp(3'b010, 32'd5, 32'd7));
        run_op(3'b010, 32'd5, 32'd7, 0);

        check1("exp_q_empty", exp_q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
